// File: rtl/wb_port_arbiter_pkg.sv
// Shared LC-3b register-file types and the writeback-port arbiter state encoding.
package lc3b_types;

   typedef logic [2:0]  lc3b_reg;
   typedef logic [15:0] lc3b_word;

   typedef enum logic {
      NORMAL,
      STARVED
   } wb_arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_return_fifo: synchronous FIFO buffering load returns; pops and pushes may share a cycle.
module wb_return_fifo #(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered load returns.
// Optional statistics counters are enabled by defining WB_PORT_ARBITER_STATS_EN.
module wb_port_arbiter
   import lc3b_types::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MAX_WAIT   = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          pipe_valid,
   input  lc3b_reg                       pipe_dest,
   input  logic [DATA_WIDTH-1:0]         pipe_data,
   output logic                          pipe_ready,
   input  logic                          mem_valid,
   input  lc3b_reg                       mem_dest,
   input  logic [DATA_WIDTH-1:0]         mem_data,
   output logic                          mem_ready,
   output logic                          rf_we,
   output lc3b_reg                       rf_idx,
   output logic [DATA_WIDTH-1:0]         rf_data,
   output logic                          sb_release,
   output lc3b_reg                       sb_release_idx,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_PORT_ARBITER_STATS_EN
   ,
   output logic [15:0]                   stat_stall_cycles,
   output logic [15:0]                   stat_drops,
   output logic [15:0]                   stat_forced
`endif
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   wb_arb_state_t                state, state_n;
   logic [WW-1:0]                wait_cnt, wait_n;
   logic [DATA_WIDTH+2:0]        head;
   lc3b_reg                      head_dest;
   logic [DATA_WIDTH-1:0]        head_data;
   logic                         fifo_empty;
   logic                         pop;
   logic                         grant_pipe;
   logic                         grant_head;
   logic                         drop;

   assign mem_ready  = (fifo_count < DEPTH_C);
   assign fifo_empty = (fifo_count == '0);
   assign head_dest  = head[DATA_WIDTH+2:DATA_WIDTH];
   assign head_data  = head[DATA_WIDTH-1:0];

   wb_return_fifo #(
      .WIDTH (DATA_WIDTH + 3),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (mem_valid && mem_ready),
      .push_data ({mem_dest, mem_data}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= NORMAL;
         wait_cnt <= '0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_n;
      end
   end

   always_comb begin
      state_n    = state;
      wait_n     = wait_cnt;
      pipe_ready = (state == NORMAL);
      pop        = 1'b0;
      grant_pipe = 1'b0;
      grant_head = 1'b0;
      drop       = 1'b0;
      case (state)
         NORMAL: begin
            if (pipe_valid) begin
               grant_pipe = 1'b1;
               if (!fifo_empty) begin
                  // Same destination: the buffered load is older, so its write is dead.
                  if (head_dest == pipe_dest) begin
                     drop   = 1'b1;
                     pop    = 1'b1;
                     wait_n = '0;
                  end else if (wait_cnt != WAIT_MAX) begin
                     wait_n = wait_cnt + WW'(1);
                  end
               end
            end else if (!fifo_empty) begin
               grant_head = 1'b1;
               pop        = 1'b1;
               wait_n     = '0;
            end
            if (wait_n == WAIT_MAX) state_n = STARVED;
         end
         STARVED: begin
            grant_head = !fifo_empty;
            pop        = !fifo_empty;
            wait_n     = '0;
            state_n    = NORMAL;
         end
         default: state_n = NORMAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we          <= 1'b0;
         rf_idx         <= '0;
         rf_data        <= '0;
         sb_release     <= 1'b0;
         sb_release_idx <= '0;
      end else begin
         rf_we      <= grant_pipe || grant_head;
         sb_release <= grant_head || drop;
         if (grant_pipe) begin
            rf_idx  <= pipe_dest;
            rf_data <= pipe_data;
         end else if (grant_head) begin
            rf_idx  <= head_dest;
            rf_data <= head_data;
         end
         if (grant_head || drop) sb_release_idx <= head_dest;
      end
   end

`ifdef WB_PORT_ARBITER_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_stall_cycles <= '0;
         stat_drops        <= '0;
         stat_forced       <= '0;
      end else begin
         if (pipe_valid && !pipe_ready && stat_stall_cycles != '1)
            stat_stall_cycles <= stat_stall_cycles + 16'd1;
         if (drop && stat_drops != '1)
            stat_drops <= stat_drops + 16'd1;
         if (state == STARVED && grant_head && stat_forced != '1)
            stat_forced <= stat_forced + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios then random traffic vs a queue model.
module tb_wb_port_arbiter;

   localparam int DEPTH = 2;
   localparam int MAXW  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        pipe_valid;
   logic [2:0]  pipe_dest;
   logic [15:0] pipe_data;
   logic        pipe_ready;
   logic        mem_valid;
   logic [2:0]  mem_dest;
   logic [15:0] mem_data;
   logic        mem_ready;
   logic        rf_we;
   logic [2:0]  rf_idx;
   logic [15:0] rf_data;
   logic        sb_release;
   logic [2:0]  sb_release_idx;
   logic [1:0]  fifo_count;
`ifdef WB_PORT_ARBITER_STATS_EN
   logic [15:0] stat_stall_cycles, stat_drops, stat_forced;
`endif

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .DATA_WIDTH (16),
      .FIFO_DEPTH (DEPTH),
      .MAX_WAIT   (MAXW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pipe_valid     (pipe_valid),
      .pipe_dest      (pipe_dest),
      .pipe_data      (pipe_data),
      .pipe_ready     (pipe_ready),
      .mem_valid      (mem_valid),
      .mem_dest       (mem_dest),
      .mem_data       (mem_data),
      .mem_ready      (mem_ready),
      .rf_we          (rf_we),
      .rf_idx         (rf_idx),
      .rf_data        (rf_data),
      .sb_release     (sb_release),
      .sb_release_idx (sb_release_idx),
      .fifo_count     (fifo_count)
`ifdef WB_PORT_ARBITER_STATS_EN
      ,
      .stat_stall_cycles (stat_stall_cycles),
      .stat_drops        (stat_drops),
      .stat_forced       (stat_forced)
`endif
   );

   typedef struct {
      logic [2:0]  dest;
      logic [15:0] data;
   } ent_t;

   ent_t        q[$];
   int          passes;
   bit          starved;
   logic        e_we, e_rel;
   logic [2:0]  e_idx, e_ridx;
   logic [15:0] e_data;
   int          e_stall, e_drops, e_forced;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      passes = 0; starved = 0;
      e_we = 0; e_rel = 0; e_idx = 0; e_ridx = 0; e_data = 0;
      e_stall = 0; e_drops = 0; e_forced = 0;
   endtask

   function automatic int sat16(input int v);
      return (v > 16'hFFFF) ? 16'hFFFF : v;
   endfunction

   // Arbitration rules applied to the queue, producing next-cycle register outputs.
   task automatic model_step();
      ent_t e;
      bit   can_push;
      if (reset) begin
         model_clear();
         return;
      end
      can_push = mem_valid && (q.size() < DEPTH);
      e_we = 0; e_rel = 0;
      if (pipe_valid && starved) e_stall = sat16(e_stall + 1);
      if (starved) begin
         if (q.size() > 0) begin
            e = q.pop_front();
            e_we = 1; e_rel = 1; e_idx = e.dest; e_ridx = e.dest; e_data = e.data;
            e_forced = sat16(e_forced + 1);
         end
         starved = 0; passes = 0;
      end else if (pipe_valid) begin
         e_we = 1; e_idx = pipe_dest; e_data = pipe_data;
         if (q.size() > 0) begin
            if (q[0].dest == pipe_dest) begin
               e = q.pop_front();
               e_rel = 1; e_ridx = e.dest; passes = 0;
               e_drops = sat16(e_drops + 1);
            end else begin
               passes = (passes + 1 > MAXW) ? MAXW : passes + 1;
            end
         end
         if (passes == MAXW) starved = 1;
      end else if (q.size() > 0) begin
         e = q.pop_front();
         e_we = 1; e_rel = 1; e_idx = e.dest; e_ridx = e.dest; e_data = e.data;
         passes = 0;
      end
      if (can_push) begin
         e.dest = mem_dest; e.data = mem_data;
         q.push_back(e);
      end
   endtask

   task automatic check_regs();
      chk("rf_we", rf_we, e_we);
      chk("rf_idx", rf_idx, e_idx);
      chk("rf_data", rf_data, e_data);
      chk("sb_release", sb_release, e_rel);
      chk("sb_release_idx", sb_release_idx, e_ridx);
`ifdef WB_PORT_ARBITER_STATS_EN
      chk("stat_stall", stat_stall_cycles, e_stall);
      chk("stat_drops", stat_drops, e_drops);
      chk("stat_forced", stat_forced, e_forced);
`endif
   endtask

   // Inputs are changed only at the falling edge; each tick covers one rising edge.
   task automatic tick();
      chk("pipe_ready", pipe_ready, !starved);
      chk("mem_ready", mem_ready, q.size() < DEPTH);
      chk("fifo_count", fifo_count, q.size());
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_regs();
   endtask

   task automatic idle_inputs();
      reset = 0; pipe_valid = 0; mem_valid = 0;
      pipe_dest = 0; pipe_data = 0; mem_dest = 0; mem_data = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_clear();
      reset = 0;
      check_regs();
      tick(); tick();

      // Pipeline-only write.
      pipe_valid = 1; pipe_dest = 3; pipe_data = 16'h1234;
      tick();
      chk("pipe_write_data", rf_data, 16'h1234);
      idle_inputs();

      // Lone load return, granted the cycle after its push.
      mem_valid = 1; mem_dest = 5; mem_data = 16'hBEEF;
      tick();
      idle_inputs();
      tick();
      chk("load_release_idx", sb_release_idx, 3'd5);
      tick();

      // Starvation: R2 buffered, pipeline R1 held continuously.
      mem_valid = 1; mem_dest = 2; mem_data = 16'h2222;
      tick();
      idle_inputs();
      pipe_valid = 1; pipe_dest = 1; pipe_data = 16'h1111;
      repeat (3) tick();
      chk("starved_stall", pipe_ready, 1'b0);
      tick();
      chk("forced_write_idx", rf_idx, 3'd2);
      tick(); tick();
      idle_inputs();
      tick();

      // WAW drop: head R4 with pipeline R4.
      mem_valid = 1; mem_dest = 4; mem_data = 16'h4444;
      tick();
      idle_inputs();
      pipe_valid = 1; pipe_dest = 4; pipe_data = 16'h0007;
      tick();
      chk("drop_count", fifo_count, 2'd0);
      idle_inputs();
      tick();

      // Fill, then reset while full.
      mem_valid = 1; mem_dest = 6; mem_data = 16'h6666;
      pipe_valid = 1; pipe_dest = 0; pipe_data = 16'h0A0A;
      tick();
      mem_dest = 7; mem_data = 16'h7777;
      tick();
      chk("full_mem_ready", mem_ready, 1'b0);
      mem_dest = 3;
      tick();
      idle_inputs();
      reset = 1;
      tick();
      reset = 0;
      tick();
      chk("reset_flush_count", fifo_count, 2'd0);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 59) == 0);
         pipe_valid = $urandom_range(0, 99) < 55;
         pipe_dest  = 3'($urandom_range(0, 3));
         pipe_data  = 16'($urandom);
         mem_valid  = $urandom_range(0, 99) < 45;
         mem_dest   = 3'($urandom_range(0, 3));
         mem_data   = 16'($urandom);
         tick();
      end
      idle_inputs();
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
